// File: rtl/clint_pkg.sv
// Shared constants and helpers for the CLINT-style machine timer.
package clint_pkg;
  localparam logic [15:0] MSIP_OFS     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFS = 16'h4000;
  localparam logic [15:0] MTIME_OFS    = 16'hbff8;
  localparam int          CMP_STRIDE   = 8;
  localparam int          MAX_CHANNELS = 8;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = mask[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return res;
  endfunction
endpackage

// File: rtl/clint_prescaler.sv
// Free-running divider: tick is high on the last of every PRESCALE clocks.
module clint_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == 16'(PRESCALE - 1));
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 16'd0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/clint_timer.sv
// Memory-mapped machine timer: 64-bit mtime, CHANNELS mtimecmp comparators.
// Optional per-channel software interrupt registers under CLINT_MSIP_EN.
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4400_0000,
  parameter int          CHANNELS  = 1,
  parameter int          PRESCALE  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  input  logic                mem_write,
  input  logic [3:0]          mem_wmask,
  input  logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_addr,
  output logic [31:0]         mem_rdata,
  output logic                mem_hit,
  output logic [CHANNELS-1:0] irq_timer,
`ifdef CLINT_MSIP_EN
  output logic [CHANNELS-1:0] irq_soft,
`endif
  output logic [63:0]         mtime
);
  localparam int          NCH        = (CHANNELS > MAX_CHANNELS) ? MAX_CHANNELS : CHANNELS;
  localparam logic [13:0] MTIME_LO_W = MTIME_OFS[15:2];
  localparam logic [13:0] MTIME_HI_W = MTIME_OFS[15:2] + 14'd1;

  function automatic logic [13:0] cmp_word(input int ch, input logic hi);
    return 14'((MTIMECMP_OFS >> 2) + 16'(ch * (CMP_STRIDE / 4))) + {13'd0, hi};
  endfunction

  logic                tick;
  logic                hit, wr;
  logic [13:0]         word;
  logic [31:0]         rd_word;
  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         mtimecmp_q [CHANNELS];
  logic [63:0]         mtimecmp_d [CHANNELS];
  logic [CHANNELS-1:0] irq_q, irq_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                hit_q, hit_d;
  logic                unused_addr;
`ifdef CLINT_MSIP_EN
  logic [CHANNELS-1:0] msip_q, msip_d;
`endif

  assign unused_addr = ^mem_addr[1:0];

  clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    hit        = mem_valid && (mem_addr[31:16] == BASE_ADDR[31:16]);
    wr         = hit && mem_write;
    word       = mem_addr[15:2];
    rd_word    = 32'd0;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    irq_d      = '0;
`ifdef CLINT_MSIP_EN
    msip_d     = msip_q;
`endif

    // A write to either mtime word replaces this cycle's increment.
    if (word == MTIME_LO_W) begin
      rd_word = mtime_q[31:0];
      if (wr) mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], mem_wdata, mem_wmask)};
    end
    if (word == MTIME_HI_W) begin
      rd_word = mtime_q[63:32];
      if (wr) mtime_d = {byte_merge(mtime_q[63:32], mem_wdata, mem_wmask), mtime_q[31:0]};
    end

    for (int i = 0; i < NCH; i++) begin
      if (word == cmp_word(i, 1'b0)) begin
        rd_word = mtimecmp_q[i][31:0];
        if (wr) mtimecmp_d[i][31:0] = byte_merge(mtimecmp_q[i][31:0], mem_wdata, mem_wmask);
      end
      if (word == cmp_word(i, 1'b1)) begin
        rd_word = mtimecmp_q[i][63:32];
        if (wr) mtimecmp_d[i][63:32] = byte_merge(mtimecmp_q[i][63:32], mem_wdata, mem_wmask);
      end
`ifdef CLINT_MSIP_EN
      if (word == 14'((MSIP_OFS >> 2) + 16'(i))) begin
        rd_word = {31'd0, msip_q[i]};
        if (wr && mem_wmask[0]) msip_d[i] = mem_wdata[0];
      end
`endif
      irq_d[i] = (mtime_q >= mtimecmp_q[i]);
    end

    // Response registers hold until the next accepted request.
    rdata_d = rdata_q;
    hit_d   = hit_q;
    if (mem_valid) begin
      hit_d   = hit;
      rdata_d = hit ? rd_word : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= 64'd0;
      for (int i = 0; i < CHANNELS; i++) mtimecmp_q[i] <= '1;
      irq_q   <= '0;
      rdata_q <= 32'd0;
      hit_q   <= 1'b0;
`ifdef CLINT_MSIP_EN
      msip_q  <= '0;
`endif
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
`ifdef CLINT_MSIP_EN
      msip_q     <= msip_d;
`endif
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_hit   = hit_q;
  assign irq_timer = irq_q;
  assign mtime     = mtime_q;
`ifdef CLINT_MSIP_EN
  assign irq_soft  = msip_q;
`endif
endmodule
